text_fetch_ctrl: RTL and testbench



---
 rtl/video_timing_pkg.sv | 32 +++
 rtl/text_fetch_ctrl_if.sv | 11 +
 rtl/video_timing_gen.sv | 69 ++++++
 rtl/text_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_text_fetch_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing constants and the per-pixel control word carried down the fetch pipeline.
package video_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 400;
  localparam int unsigned V_FP_DEF      = 12;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 35;

  localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned LATENCY = 3;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned CHAR_H  = 16;
  localparam int unsigned HCW     = 10;
  localparam int unsigned VCW     = 9;
  localparam int unsigned ADDR_W  = 11;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [3:0] grow;
    logic [2:0] gcol;
  } pix_ctl_t;

endpackage

// File: rtl/text_fetch_ctrl_if.sv
// Video character RAM read port: address out, registered data back one clock later.
interface text_fetch_ctrl_if;
  import video_timing_pkg::*;

  logic [ADDR_W-1:0] read_ad;
  logic [7:0]        read_data;

  modport master (output read_ad, input read_data);
  modport slave  (input read_ad, output read_data);

endinterface

// File: rtl/video_timing_gen.sv
// Raster counters with sync levels, active flag and frame/line markers at counter stage 0.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  output logic [HCW-1:0] hcount_o,
  output logic [3:0]     cell_row_o,
  output logic           active_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           frame_first_o,
  output logic           line_end_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [HCW-1:0] HLast    = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] HVis     = HCW'(H_VISIBLE);
  localparam logic [HCW-1:0] HsStart  = HCW'(H_VISIBLE + H_FP);
  localparam logic [HCW-1:0] HsEnd    = HCW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] VLast    = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] VVis     = VCW'(V_VISIBLE);
  localparam logic [VCW-1:0] VsStart  = VCW'(V_VISIBLE + V_FP);
  localparam logic [VCW-1:0] VsEnd    = VCW'(V_VISIBLE + V_FP + V_SYNC);

  logic [HCW-1:0] hcount_q, hcount_d;
  logic [VCW-1:0] vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == HLast) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign cell_row_o    = vcount_q[3:0];
  assign active_o      = (hcount_q < HVis) && (vcount_q < VVis);
  assign hsync_o       = (hcount_q >= HsStart && hcount_q < HsEnd) ? HS_POL : ~HS_POL;
  assign vsync_o       = (vcount_q >= VsStart && vcount_q < VsEnd) ? VS_POL : ~VS_POL;
  assign frame_first_o = (hcount_q == '0) && (vcount_q == '0);
  assign line_end_o    = (hcount_q == HLast);

endmodule

// File: rtl/text_fetch_ctrl.sv
// Text-mode scan controller: scrolled character-cell addressing into video RAM and a
// 3-stage pipe that lines sync/enable/glyph position up with the returned character code.
module text_fetch_ctrl
  import video_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter int unsigned COLS      = H_VISIBLE / CHAR_W,
  parameter int unsigned ROWS      = V_VISIBLE / CHAR_H,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         scroll_row,
  text_fetch_ctrl_if.master  vram,
  output logic [7:0]         char_code,
  output logic [3:0]         glyph_row,
  output logic [2:0]         glyph_col,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(COLS);
  localparam logic [4:0]        RowsA    = 5'(ROWS);
  localparam logic [4:0]        RowsLast = 5'(ROWS - 1);
  localparam pix_ctl_t PixIdle = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, fs: 1'b0,
                                   grow: 4'd0, gcol: 3'd0};

  logic [HCW-1:0] hcount;
  logic [3:0]     cell_row;
  logic           active, hs_lvl, vs_lvl, frame_first, line_end;

  video_timing_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk_i        (clk),
    .reset_i      (reset),
    .hcount_o     (hcount),
    .cell_row_o   (cell_row),
    .active_o     (active),
    .hsync_o      (hs_lvl),
    .vsync_o      (vs_lvl),
    .frame_first_o(frame_first),
    .line_end_o   (line_end)
  );

  logic [4:0]        scroll_eff;
  logic [4:0]        prow_q, prow_d, prow_cur;
  logic [ADDR_W-1:0] rowbase_q, rowbase_d, rowbase_cur;
  logic [ADDR_W-1:0] read_ad_q, read_ad_d;
  logic [7:0]        char_code_q, char_code_d;
  pix_ctl_t          pipe_q [LATENCY];
  pix_ctl_t          pipe_in;

  always_comb begin
    scroll_eff = (scroll_row < RowsA) ? scroll_row : 5'd0;
    // Scroll is taken on the first pixel of the frame, so that pixel bypasses the stale base.
    prow_cur    = frame_first ? scroll_eff : prow_q;
    rowbase_cur = frame_first ? ADDR_W'(scroll_eff) * ColsA : rowbase_q;
    prow_d      = prow_cur;
    rowbase_d   = rowbase_cur;
    if (line_end && cell_row == 4'hf) begin
      if (prow_cur == RowsLast) begin
        prow_d    = '0;
        rowbase_d = '0;
      end else begin
        prow_d    = prow_cur + 1'b1;
        rowbase_d = rowbase_cur + ColsA;
      end
    end

    read_ad_d = active ? rowbase_cur + ADDR_W'(hcount[9:3]) : '0;

    pipe_in = '{de: active, hs: hs_lvl, vs: vs_lvl, fs: frame_first,
                grow: cell_row, gcol: hcount[2:0]};
    // pipe_q[1] is the stage whose RAM data is arriving now.
    char_code_d = pipe_q[1].de ? vram.read_data : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prow_q      <= '0;
      rowbase_q   <= '0;
      read_ad_q   <= '0;
      char_code_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= PixIdle;
    end else begin
      prow_q      <= prow_d;
      rowbase_q   <= rowbase_d;
      read_ad_q   <= read_ad_d;
      char_code_q <= char_code_d;
      pipe_q[0]   <= pipe_in;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vram.read_ad = read_ad_q;
  assign char_code    = char_code_q;
  assign de           = pipe_q[LATENCY-1].de;
  assign hsync        = pipe_q[LATENCY-1].hs;
  assign vsync        = pipe_q[LATENCY-1].vs;
  assign frame_start  = pipe_q[LATENCY-1].fs;
  assign glyph_row    = pipe_q[LATENCY-1].grow;
  assign glyph_col    = pipe_q[LATENCY-1].gcol;

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Directed bench for text_fetch_ctrl on a reduced raster (80x105, 8x6 cells) with mem[a]=a[7:0].
module tb_text_fetch_ctrl;

  localparam int HT    = 80;
  localparam int VT    = 105;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] scroll_row = 5'd0;
  logic [7:0] char_code;
  logic [3:0] glyph_row;
  logic [2:0] glyph_col;
  logic       de, hsync, vsync, frame_start;
  int         tick;
  int         n_vec = 0;
  int         n_bad = 0;

  text_fetch_ctrl_if vram_if ();

  text_fetch_ctrl #(
    .H_VISIBLE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VISIBLE(96), .V_FP(3), .V_SYNC(2), .V_BP(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scroll_row (scroll_row),
    .vram       (vram_if.master),
    .char_code  (char_code),
    .glyph_row  (glyph_row),
    .glyph_col  (glyph_col),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Registered-read RAM holding mem[a] = a[7:0].
  always @(posedge clk) vram_if.read_data <= vram_if.read_ad[7:0];

  // tick == counter position of stage 0 (0 on the first cycle after reset release).
  always @(posedge clk) tick <= reset ? 0 : tick + 1;

  typedef struct {
    int         frame;
    int         line;
    int         pix;
    logic [4:0] scroll;
    logic [10:0] ad;
    logic       de;
    logic [7:0] ch;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [3:0] gr;
    logic [2:0] gc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic wait_tick(input int target);
    while (tick < target) @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input int idx, input logic d, input logic [7:0] c,
                          input logic f, input logic h, input logic v, input logic [3:0] r,
                          input logic [2:0] g);
    chk({tag, ".de"}, idx, 32'(de), 32'(d));
    chk({tag, ".char_code"}, idx, 32'(char_code), 32'(c));
    chk({tag, ".frame_start"}, idx, 32'(frame_start), 32'(f));
    chk({tag, ".hsync"}, idx, 32'(hsync), 32'(h));
    chk({tag, ".vsync"}, idx, 32'(vsync), 32'(v));
    chk({tag, ".glyph_row"}, idx, 32'(glyph_row), 32'(r));
    chk({tag, ".glyph_col"}, idx, 32'(glyph_col), 32'(g));
  endtask

  initial begin
    int p;
    //            frm line pix scrl  ad  de  ch  fs hs vs gr gc
    vecs.push_back('{0,   0,  0, 0,   0, 1,  0, 1, 1, 0, 0, 0});
    vecs.push_back('{0,   0,  8, 0,   1, 1,  1, 0, 1, 0, 0, 0});
    vecs.push_back('{0,   0, 63, 0,   7, 1,  7, 0, 1, 0, 0, 7});
    vecs.push_back('{0,   0, 64, 0,   0, 0,  0, 0, 1, 0, 0, 0});
    vecs.push_back('{0,   0, 68, 0,   0, 0,  0, 0, 0, 0, 0, 4});
    vecs.push_back('{0,   0, 74, 0,   0, 0,  0, 0, 0, 0, 0, 2});
    vecs.push_back('{0,   0, 76, 0,   0, 0,  0, 0, 1, 0, 0, 4});
    vecs.push_back('{0,  16,  0, 0,   8, 1,  8, 0, 1, 0, 0, 0});
    vecs.push_back('{0,  17, 13, 0,   9, 1,  9, 0, 1, 0, 1, 5});
    vecs.push_back('{0,  95, 63, 0,  47, 1, 47, 0, 1, 0,15, 7});
    vecs.push_back('{0,  96,  0, 0,   0, 0,  0, 0, 1, 0, 0, 0});
    vecs.push_back('{0,  99,  5, 0,   0, 0,  0, 0, 1, 1, 3, 5});
    vecs.push_back('{0, 100, 70, 0,   0, 0,  0, 0, 0, 1, 4, 6});
    vecs.push_back('{0, 101,  0, 0,   0, 0,  0, 0, 1, 0, 5, 0});
    vecs.push_back('{0, 104, 60, 0,   0, 0,  0, 0, 1, 0, 8, 4});
    vecs.push_back('{1,   0,  0, 5,  40, 1, 40, 1, 1, 0, 0, 0});
    vecs.push_back('{1,  16,  9, 5,   1, 1,  1, 0, 1, 0, 0, 1});
    vecs.push_back('{1,  50,  3, 2,  16, 1, 16, 0, 1, 0, 2, 3});
    vecs.push_back('{1,  95, 63, 2,  39, 1, 39, 0, 1, 0,15, 7});
    vecs.push_back('{2,   0,  2, 2,  16, 1, 16, 0, 1, 0, 0, 2});
    vecs.push_back('{2,  64,  7, 2,   0, 1,  0, 0, 1, 0, 0, 7});
    vecs.push_back('{2,  80, 15, 30,  9, 1,  9, 0, 1, 0, 0, 7});
    vecs.push_back('{3,   0,  0, 30,  0, 1,  0, 1, 1, 0, 0, 0});
    vecs.push_back('{3,  32, 24, 6,  19, 1, 19, 0, 1, 0, 0, 0});
    vecs.push_back('{4,  16,  0, 6,   8, 1,  8, 0, 1, 0, 0, 0});

    repeat (3) @(negedge clk);
    chk_outs("reset", -1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    chk("reset.read_ad", -1, 32'(vram_if.read_ad), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      scroll_row = vecs[i].scroll;
      p = vecs[i].frame * FRAME + vecs[i].line * HT + vecs[i].pix;
      wait_tick(p + 1);
      chk("read_ad", i, 32'(vram_if.read_ad), 32'(vecs[i].ad));
      wait_tick(p + 3);
      chk_outs("vec", i, vecs[i].de, vecs[i].ch, vecs[i].fs, vecs[i].hs, vecs[i].vs,
               vecs[i].gr, vecs[i].gc);
    end

    // Mid-line reset in frame 4 at line 40, pixel 30; outputs currently show pixel 27.
    wait_tick(4 * FRAME + 40 * HT + 30);
    chk_outs("pre_rst", 0, 1'b1, 8'd19, 1'b0, 1'b1, 1'b0, 4'd8, 3'd3);
    reset = 1'b1;
    @(negedge clk);
    chk_outs("in_rst", 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    chk("in_rst.read_ad", 0, 32'(vram_if.read_ad), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_tick(2);
    chk("post_rst.frame_start_early", 0, 32'(frame_start), 32'd0);
    wait_tick(3);
    chk_outs("post_rst.first", 0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0);
    wait_tick(11);
    chk("post_rst.read_ad", 0, 32'(vram_if.read_ad), 32'd1);
    chk_outs("post_rst.cell1", 0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
